eq_gain_ctrl: RTL and testbench

- Clock-domain controller between the SPI equalizer-word receiver and the audio equalizer datapath.
- Detects the end of each 32-bit SPI frame (load falling) in the clk domain, captures and validates the 8-band gain word, then ramps the active band gains toward the new target one step per sample boundary.
- Ramping avoids zipper noise and makes every gain change sample-aligned.

---
 rtl/eq_gain_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_eq_gain_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_ctrl.sv
// Equalizer gain controller: syncs the SPI frame strobe into clk, validates the
// captured band-gain word and ramps the live gains toward it on sample ticks.
module eq_gain_ctrl #(
    parameter int NBANDS   = 8,
    parameter int GW       = 4,
    parameter int MAX_GAIN = 12,
    parameter int UNITY    = 8,
    parameter int RAMP_DIV = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NBANDS*GW-1:0]   eq_word,
    input  logic                   sample_tick,
    output logic [NBANDS*GW-1:0]   gains,
    output logic                   busy,
    output logic                   cfg_err,
    output logic [7:0]             frame_cnt
);

    localparam int            W         = NBANDS * GW;
    localparam logic [GW-1:0] UNITY_G   = GW'(UNITY);
    localparam logic [GW-1:0] MAX_G     = GW'(MAX_GAIN);
    localparam logic [W-1:0]  RST_GAINS = {NBANDS{UNITY_G}};
    localparam logic [7:0]    DIV_LAST  = 8'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_RAMP    = 2'd3
    } state_t;

    // True when any band code exceeds the legal maximum.
    function automatic logic any_over(input logic [W-1:0] w);
        logic r;
        r = 1'b0;
        for (int b = 0; b < NBANDS; b++) begin
            r = r | (w[b*GW +: GW] > MAX_G);
        end
        return r;
    endfunction

    // Move every band one code toward its target, saturating at the target.
    function automatic logic [W-1:0] step_gains(input logic [W-1:0] cur,
                                                input logic [W-1:0] tgt);
        logic [W-1:0] r;
        r = cur;
        for (int b = 0; b < NBANDS; b++) begin
            if (cur[b*GW +: GW] < tgt[b*GW +: GW]) begin
                r[b*GW +: GW] = cur[b*GW +: GW] + {{(GW-1){1'b0}}, 1'b1};
            end else if (cur[b*GW +: GW] > tgt[b*GW +: GW]) begin
                r[b*GW +: GW] = cur[b*GW +: GW] - {{(GW-1){1'b0}}, 1'b1};
            end else begin
                r[b*GW +: GW] = cur[b*GW +: GW];
            end
        end
        return r;
    endfunction

    state_t         r_state;
    state_t         w_next_state;
    logic           r_load_meta;
    logic           r_load_s;
    logic           r_load_d;
    logic           w_frame_end;
    logic           r_pending;
    logic           w_pending_nx;
    logic [W-1:0]   r_shadow;
    logic [W-1:0]   r_target;
    logic [W-1:0]   r_gains;
    logic [W-1:0]   w_gains_nx;
    logic [W-1:0]   w_stepped;
    logic [7:0]     r_div;
    logic [7:0]     w_div_nx;
    logic           w_accept;
    logic           w_reject;
    logic           r_busy;
    logic           r_cfg_err;
    logic [7:0]     r_frame_cnt;

    assign w_frame_end = r_load_d & ~r_load_s;
    assign w_stepped   = step_gains(r_gains, r_target);

    // Two-flop synchronizer plus delay flop for the asynchronous frame strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_meta <= 1'b0;
            r_load_s    <= 1'b0;
            r_load_d    <= 1'b0;
        end else begin
            r_load_meta <= load;
            r_load_s    <= r_load_meta;
            r_load_d    <= r_load_s;
        end
    end

    // Next-state, pending-frame, divider and gain-step decisions.
    always_comb begin
        w_next_state = r_state;
        w_pending_nx = r_pending;
        w_gains_nx   = r_gains;
        w_div_nx     = r_div;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_frame_end || r_pending) begin
                    w_next_state = ST_CAPTURE;
                    w_pending_nx = 1'b0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                w_next_state = ST_CHECK;
                if (w_frame_end) begin
                    w_pending_nx = 1'b1;
                end else begin
                    w_pending_nx = r_pending;
                end
            end
            ST_CHECK: begin
                if (w_frame_end) begin
                    w_pending_nx = 1'b1;
                end else begin
                    w_pending_nx = r_pending;
                end
                // A rejected frame resumes any ramp that was already underway.
                if (any_over(r_shadow)) begin
                    w_reject     = 1'b1;
                    w_next_state = (r_gains != r_target) ? ST_RAMP : ST_IDLE;
                end else begin
                    w_accept     = 1'b1;
                    w_next_state = (r_shadow != r_gains) ? ST_RAMP : ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (sample_tick) begin
                    if (r_div == DIV_LAST) begin
                        w_gains_nx = w_stepped;
                        w_div_nx   = 8'd0;
                    end else begin
                        w_div_nx   = r_div + 8'd1;
                    end
                end else begin
                    w_div_nx = r_div;
                end
                if (w_frame_end || r_pending) begin
                    w_next_state = ST_CAPTURE;
                    w_pending_nx = 1'b0;
                end else if (w_gains_nx == r_target) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RAMP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Controller state, frame capture, ramp registers and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_shadow    <= RST_GAINS;
            r_target    <= RST_GAINS;
            r_gains     <= RST_GAINS;
            r_div       <= 8'd0;
            r_busy      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_nx;
            r_gains   <= w_gains_nx;
            r_div     <= w_div_nx;
            r_busy    <= (w_next_state == ST_RAMP);
            if (r_state == ST_CAPTURE) begin
                r_shadow <= eq_word;
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_accept) begin
                r_target    <= r_shadow;
                r_cfg_err   <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (w_reject) begin
                r_target    <= r_target;
                r_cfg_err   <= 1'b1;
                r_frame_cnt <= r_frame_cnt;
            end else begin
                r_target    <= r_target;
                r_cfg_err   <= r_cfg_err;
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    assign gains     = r_gains;
    assign busy      = r_busy;
    assign cfg_err   = r_cfg_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Directed bench for eq_gain_ctrl: one instance at RAMP_DIV=1, one at RAMP_DIV=4.
module tb_eq_gain_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reset4 = 1'b0;
    logic        load = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] eq_word = 32'h0;
    logic [31:0] gains, gains4;
    logic        busy, busy4, cfg_err, cfg_err4;
    logic [7:0]  frame_cnt, frame_cnt4;
    int          total = 0;
    int          bad = 0;

    eq_gain_ctrl #(.RAMP_DIV(1)) dut (
        .clk(clk), .reset(reset), .load(load), .eq_word(eq_word),
        .sample_tick(sample_tick), .gains(gains), .busy(busy),
        .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    eq_gain_ctrl #(.RAMP_DIV(4)) dut4 (
        .clk(clk), .reset(reset4), .load(load), .eq_word(eq_word),
        .sample_tick(sample_tick), .gains(gains4), .busy(busy4),
        .cfg_err(cfg_err4), .frame_cnt(frame_cnt4)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        eq_word = w;
        load = 1'b1;
        step(2);
        load = 1'b0;
        step(6);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_gains", gains, 32'h88888888);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        reset = 1'b1;
        step(2);

        // basic accepted frame and busy latency
        eq_word = 32'h9888888A;
        load = 1'b1;
        step(2);
        load = 1'b0;
        step(4);
        chk("busy_early", {31'd0, busy}, 32'd0);
        step(1);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("gains_hold", gains, 32'h88888888);
        tick();
        chk("tick1", gains, 32'h98888889);
        tick();
        chk("tick2", gains, 32'h9888888A);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("cnt1", {24'd0, frame_cnt}, 32'd1);
        tick();
        tick();
        chk("no_overshoot", gains, 32'h9888888A);

        // rejected then accepted frame
        send(32'h888D8888);
        chk("rej_err", {31'd0, cfg_err}, 32'd1);
        chk("rej_gains", gains, 32'h9888888A);
        chk("rej_cnt", {24'd0, frame_cnt}, 32'd1);
        chk("rej_busy", {31'd0, busy}, 32'd0);
        send(32'h9888888A);
        chk("acc_err", {31'd0, cfg_err}, 32'd0);
        chk("acc_cnt", {24'd0, frame_cnt}, 32'd2);
        chk("acc_busy", {31'd0, busy}, 32'd0);
        send(32'hD0000000);
        chk("rej2_err", {31'd0, cfg_err}, 32'd1);

        // asynchronous reset without a clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("async_gains", gains, 32'h88888888);
        chk("async_err", {31'd0, cfg_err}, 32'd0);
        chk("async_cnt", {24'd0, frame_cnt}, 32'd0);
        step(1);
        reset = 1'b1;
        step(1);

        // retarget mid-ramp; all bands at MAX_GAIN are legal
        send(32'hCCCCCCCC);
        chk("max_cnt", {24'd0, frame_cnt}, 32'd1);
        chk("max_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        chk("mid_ramp", gains, 32'hAAAAAAAA);
        send(32'h00000000);
        chk("retgt_hold", gains, 32'hAAAAAAAA);
        chk("retgt_cnt", {24'd0, frame_cnt}, 32'd2);
        repeat (9) tick();
        chk("desc9", gains, 32'h11111111);
        chk("desc9_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("desc10", gains, 32'h00000000);
        chk("desc10_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        chk("idle_ticks", gains, 32'h00000000);

        // second frame_end lands during CHECK of the first
        eq_word = 32'h00000011;
        load = 1'b1;
        step(2);
        load = 1'b0;
        step(1);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        eq_word = 32'h00000002;
        step(8);
        chk("pend_cnt", {24'd0, frame_cnt}, 32'd4);
        chk("pend_hold", gains, 32'h00000000);
        tick();
        chk("pend_t1", gains, 32'h00000001);
        tick();
        chk("pend_t2", gains, 32'h00000002);
        chk("pend_busy", {31'd0, busy}, 32'd0);

        // frame counter wrap
        repeat (251) send(32'h00000002);
        chk("cnt255", {24'd0, frame_cnt}, 32'd255);
        send(32'h00000002);
        chk("cnt_wrap", {24'd0, frame_cnt}, 32'd0);
        chk("wrap_err", {31'd0, cfg_err}, 32'd0);

        // reset mid-ramp
        send(32'hCCCCCCCC);
        tick();
        chk("pre_rst", gains, 32'h11111113);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_ramp_gains", gains, 32'h88888888);
        chk("rst_ramp_busy", {31'd0, busy}, 32'd0);
        step(1);
        reset = 1'b1;
        step(1);

        // RAMP_DIV=4 instance; idle ticks must not pre-advance the divider
        reset4 = 1'b1;
        step(2);
        repeat (10) tick();
        chk("d4_idle", gains4, 32'h88888888);
        send(32'h88888889);
        chk("d4_busy", {31'd0, busy4}, 32'd1);
        repeat (3) tick();
        chk("d4_t3", gains4, 32'h88888888);
        chk("d4_t3_busy", {31'd0, busy4}, 32'd1);
        tick();
        chk("d4_t4", gains4, 32'h88888889);
        chk("d4_done", {31'd0, busy4}, 32'd0);
        chk("d4_cnt", {24'd0, frame_cnt4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
